// File: rtl/thumb_decode_queue.sv
// Thumb/Thumb-2 fetch-to-decode stage: joins halfwords into instructions, classifies ADC/ADD/ADR forms,
// and queues the results in a DEPTH-entry FIFO. Define THUMB_EXPAND_IMM_EN to expand the pattern-1 immediate.
module thumb_decode_queue #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [15:0]       fetch_hw,
   input  logic [ADDR_W-1:0] fetch_pc,
   input  logic              fetch_valid,
   output logic              fetch_ready,
   input  logic              carry_in,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [31:0]       dec_inst,
   output logic [ADDR_W-1:0] dec_pc,
   output logic              dec_is32,
   output logic [3:0]        dec_pat,
   output logic              dec_undef,
   output logic [3:0]        dec_rd,
   output logic [3:0]        dec_rn,
   output logic [3:0]        dec_rm,
   output logic [31:0]       dec_imm32,
   output logic              dec_imm_or_reg,
   output logic              dec_shift_or_not,
   output logic [1:0]        dec_s_type,
   output logic [4:0]        dec_offset,
   output logic              dec_carry_out,
   output logic [$clog2(DEPTH):0] dec_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {IDLE, HALF} state_t;

   typedef struct packed {
      logic [31:0]       inst;
      logic [ADDR_W-1:0] pc;
      logic              is32;
      logic [3:0]        pat;
      logic [3:0]        rd;
      logic [3:0]        rn;
      logic [3:0]        rm;
      logic [31:0]       imm32;
      logic              imm_or_reg;
      logic              shift_or_not;
      logic [1:0]        s_type;
      logic [4:0]        offset;
      logic              carry_out;
   } entry_t;

   state_t            state_reg;
   logic [15:0]       hw0_reg;
   logic [ADDR_W-1:0] pc0_reg;
   entry_t            mem [DEPTH];
   logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]     count_reg;

   logic              is_prefix, accept, complete, push, pop;
   logic [31:0]       cand_inst;
   logic [ADDR_W-1:0] cand_pc;
   logic              cand_is32;
   logic [11:0]       imm12;
   logic [31:0]       p1_imm;
   logic              p1_carry;
   entry_t            dec_next, head;

   assign fetch_ready = (count_reg != FULL);
   assign dec_valid   = (count_reg != '0);
   assign is_prefix   = (fetch_hw[15:13] == 3'b111) && (fetch_hw[12:11] != 2'b00);
   assign accept      = fetch_valid & fetch_ready & ~flush;
   assign complete    = (state_reg == HALF) | ~is_prefix;
   assign push        = accept & complete;
   assign pop         = dec_valid & dec_ready & ~flush;

   always_comb begin
      if (state_reg == HALF) begin
         cand_inst = {hw0_reg, fetch_hw};
         cand_pc   = pc0_reg;
         cand_is32 = 1'b1;
      end else begin
         cand_inst = {fetch_hw, 16'h0000};
         cand_pc   = fetch_pc;
         cand_is32 = 1'b0;
      end
   end

   assign imm12 = {cand_inst[26], cand_inst[14:12], cand_inst[7:0]};

`ifdef THUMB_EXPAND_IMM_EN
   logic [31:0] unrot;
   logic [4:0]  amt;
   assign unrot = {24'b0, 1'b1, imm12[6:0]};
   assign amt   = imm12[11:7];

   always_comb begin
      p1_imm   = (unrot >> amt) | (unrot << (6'd32 - {1'b0, amt}));
      p1_carry = p1_imm[31];
      if (imm12[11:10] == 2'b00) begin
         p1_carry = carry_in;
         case (imm12[9:8])
            2'b00:   p1_imm = {24'b0, imm12[7:0]};
            2'b01:   p1_imm = {8'b0, imm12[7:0], 8'b0, imm12[7:0]};
            2'b10:   p1_imm = {imm12[7:0], 8'b0, imm12[7:0], 8'b0};
            default: p1_imm = {4{imm12[7:0]}};
         endcase
      end
   end
`else
   assign p1_imm   = {20'b0, imm12};
   assign p1_carry = carry_in;
`endif

   // Items are listed in pattern-ID order so the first (lowest) match wins.
   always_comb begin
      dec_next           = '0;
      dec_next.inst      = cand_inst;
      dec_next.pc        = cand_pc;
      dec_next.is32      = cand_is32;
      dec_next.carry_out = carry_in;
      casez (cand_inst[31:15])
         17'b11110?01010?????0, 17'b11110?01000?????0: begin
            dec_next.pat        = 4'd1;
            dec_next.rd         = cand_inst[11:8];
            dec_next.rn         = cand_inst[19:16];
            dec_next.imm32      = p1_imm;
            dec_next.imm_or_reg = 1'b1;
            dec_next.carry_out  = p1_carry;
         end
         17'b11110?100000????0, 17'b11110?10101011110: begin
            dec_next.pat        = 4'd2;
            dec_next.rd         = cand_inst[11:8];
            dec_next.rn         = cand_inst[19:16];
            dec_next.imm32      = {20'b0, imm12};
            dec_next.imm_or_reg = 1'b1;
         end
         17'b11101011010?????0, 17'b11101011000?????0: begin
            dec_next.pat          = 4'd3;
            dec_next.rd           = cand_inst[11:8];
            dec_next.rn           = cand_inst[19:16];
            dec_next.rm           = cand_inst[3:0];
            dec_next.offset       = {cand_inst[14:12], cand_inst[7:6]};
            dec_next.s_type       = cand_inst[5:4];
            dec_next.shift_or_not = 1'b1;
         end
         17'b0100000101???????: begin
            dec_next.pat = 4'd4;
            dec_next.rd  = {1'b0, cand_inst[18:16]};
            dec_next.rn  = {1'b0, cand_inst[18:16]};
            dec_next.rm  = {1'b0, cand_inst[21:19]};
         end
         17'b0001110??????????: begin
            dec_next.pat        = 4'd5;
            dec_next.rd         = {1'b0, cand_inst[18:16]};
            dec_next.rn         = {1'b0, cand_inst[21:19]};
            dec_next.imm32      = {29'b0, cand_inst[24:22]};
            dec_next.imm_or_reg = 1'b1;
         end
         17'b00110????????????, 17'b1010?????????????: begin
            dec_next.pat        = 4'd6;
            dec_next.rd         = {1'b0, cand_inst[26:24]};
            dec_next.rn         = {1'b0, cand_inst[26:24]};
            dec_next.imm32      = {24'b0, cand_inst[23:16]};
            dec_next.imm_or_reg = 1'b1;
         end
         17'b101100000????????: begin
            dec_next.pat        = 4'd7;
            dec_next.rd         = 4'd13;
            dec_next.rn         = 4'd13;
            dec_next.imm32      = {23'b0, cand_inst[22:16], 2'b00};
            dec_next.imm_or_reg = 1'b1;
         end
         17'b0001100??????????: begin
            dec_next.pat = 4'd8;
            dec_next.rd  = {1'b0, cand_inst[18:16]};
            dec_next.rn  = {1'b0, cand_inst[21:19]};
            dec_next.rm  = {1'b0, cand_inst[24:22]};
         end
         17'b01000100?????????: begin
            dec_next.pat = 4'd9;
            dec_next.rd  = {cand_inst[23], cand_inst[18:16]};
            dec_next.rm  = {cand_inst[23], cand_inst[18:16]};
            dec_next.rn  = cand_inst[22:19];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         hw0_reg   <= '0;
         pc0_reg   <= '0;
      end else if (flush) begin
         state_reg <= IDLE;
         hw0_reg   <= '0;
         pc0_reg   <= '0;
      end else if (accept) begin
         if (state_reg == HALF) begin
            state_reg <= IDLE;
         end else if (is_prefix) begin
            state_reg <= HALF;
            hw0_reg   <= fetch_hw;
            pc0_reg   <= fetch_pc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         if (push && !pop)      count_reg <= count_reg + CW'(1);
         else if (pop && !push) count_reg <= count_reg - CW'(1);
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= dec_next;
   end

   assign head             = dec_valid ? mem[rd_ptr_reg] : '0;
   assign dec_inst         = head.inst;
   assign dec_pc           = head.pc;
   assign dec_is32         = head.is32;
   assign dec_pat          = head.pat;
   assign dec_undef        = dec_valid && (head.pat == 4'd0);
   assign dec_rd           = head.rd;
   assign dec_rn           = head.rn;
   assign dec_rm           = head.rm;
   assign dec_imm32        = head.imm32;
   assign dec_imm_or_reg   = head.imm_or_reg;
   assign dec_shift_or_not = head.shift_or_not;
   assign dec_s_type       = head.s_type;
   assign dec_offset       = head.offset;
   assign dec_carry_out    = head.carry_out;
   assign dec_count        = count_reg;
endmodule

// File: tb/tb_thumb_decode_queue.sv
// Directed bench for thumb_decode_queue (DEPTH=2): reset, pattern decode, backpressure, flush, undefined.
module tb_thumb_decode_queue;
   logic        clk, rst, flush, fetch_valid, fetch_ready, carry_in;
   logic [15:0] fetch_hw;
   logic [31:0] fetch_pc;
   logic        dec_valid, dec_ready, dec_is32, dec_undef;
   logic [31:0] dec_inst, dec_pc, dec_imm32;
   logic [3:0]  dec_pat, dec_rd, dec_rn, dec_rm;
   logic        dec_imm_or_reg, dec_shift_or_not, dec_carry_out;
   logic [1:0]  dec_s_type;
   logic [4:0]  dec_offset;
   logic [1:0]  dec_count;
   int          errors = 0;
   int          checks = 0;

   thumb_decode_queue #(.DEPTH(2), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .fetch_hw(fetch_hw), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
      .fetch_ready(fetch_ready), .carry_in(carry_in),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
      .dec_is32(dec_is32), .dec_pat(dec_pat), .dec_undef(dec_undef),
      .dec_rd(dec_rd), .dec_rn(dec_rn), .dec_rm(dec_rm), .dec_imm32(dec_imm32),
      .dec_imm_or_reg(dec_imm_or_reg), .dec_shift_or_not(dec_shift_or_not),
      .dec_s_type(dec_s_type), .dec_offset(dec_offset), .dec_carry_out(dec_carry_out),
      .dec_count(dec_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] hw, input logic [31:0] pc, input logic c);
      int n = 0;
      fetch_hw    = hw;
      fetch_pc    = pc;
      carry_in    = c;
      fetch_valid = 1'b1;
      while (!fetch_ready && n < 20) begin
         tick();
         n++;
      end
      chk("send_ready", 32'(fetch_ready), 32'd1);
      tick();
      fetch_valid = 1'b0;
      $display("sent hw=0x%04h pc=0x%0h count=%0d", hw, pc, dec_count);
   endtask

   task automatic pop();
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
   endtask

   task automatic check_head(input string tag, input logic [31:0] pat, rd, rn, rm, imm, ior, sh,
                             st, off, is32, pc, inst, cout);
      chk({tag, ".valid"}, 32'(dec_valid), 32'd1);
      chk({tag, ".pat"},   32'(dec_pat), pat);
      chk({tag, ".undef"}, 32'(dec_undef), (pat == 0) ? 32'd1 : 32'd0);
      chk({tag, ".rd"},    32'(dec_rd), rd);
      chk({tag, ".rn"},    32'(dec_rn), rn);
      chk({tag, ".rm"},    32'(dec_rm), rm);
      chk({tag, ".imm"},   dec_imm32, imm);
      chk({tag, ".ior"},   32'(dec_imm_or_reg), ior);
      chk({tag, ".shift"}, 32'(dec_shift_or_not), sh);
      chk({tag, ".stype"}, 32'(dec_s_type), st);
      chk({tag, ".off"},   32'(dec_offset), off);
      chk({tag, ".is32"},  32'(dec_is32), is32);
      chk({tag, ".pc"},    dec_pc, pc);
      chk({tag, ".inst"},  dec_inst, inst);
      chk({tag, ".cout"},  32'(dec_carry_out), cout);
      $display("head %s pat=%0d rd=%0d rn=%0d rm=%0d imm=0x%0h", tag, dec_pat, dec_rd, dec_rn, dec_rm, dec_imm32);
   endtask

   logic [31:0] p1_exp;

   initial begin
`ifdef THUMB_EXPAND_IMM_EN
      p1_exp = 32'h00AB00AB;
`else
      p1_exp = 32'h000001AB;
`endif
      rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_hw = '0; fetch_pc = '0;
      carry_in = 1'b0; dec_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst.valid", 32'(dec_valid), 32'd0);
      chk("rst.count", 32'(dec_count), 32'd0);
      chk("rst.ready", 32'(fetch_ready), 32'd1);

      // Reset arriving mid-stream with one queued entry and a held first halfword.
      send(16'h3105, 32'h10, 1'b0);
      send(16'hF141, 32'h12, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("midrst.valid", 32'(dec_valid), 32'd0);
      chk("midrst.count", 32'(dec_count), 32'd0);
      chk("midrst.ready", 32'(fetch_ready), 32'd1);
      chk("midrst.pat",   32'(dec_pat), 32'd0);
      chk("midrst.inst",  dec_inst, 32'd0);
      chk("midrst.imm",   dec_imm32, 32'd0);
      chk("midrst.undef", 32'(dec_undef), 32'd0);
      tick();
      rst = 1'b0;

      send(16'h3105, 32'h100, 1'b0);
      chk("p6.count", 32'(dec_count), 32'd1);
      check_head("p6", 6, 1, 1, 0, 5, 1, 0, 0, 0, 0, 32'h100, 32'h31050000, 0);
      pop();
      chk("p6.popped", 32'(dec_valid), 32'd0);

      send(16'hF141, 32'h200, 1'b0);
      chk("p1.half_nopush", 32'(dec_valid), 32'd0);
      send(16'h12AB, 32'h202, 1'b1);
      check_head("p1", 1, 2, 1, 0, p1_exp, 1, 0, 0, 0, 1, 32'h200, 32'hF14112AB, 1);
      pop();

      send(16'hF20F, 32'h300, 1'b0);
      send(16'h3105, 32'h302, 1'b0);
      check_head("p2", 2, 1, 15, 0, 32'h305, 1, 0, 0, 0, 1, 32'h300, 32'hF20F3105, 0);
      pop();

      send(16'hEB41, 32'h400, 1'b0);
      send(16'h1253, 32'h402, 1'b0);
      check_head("p3", 3, 2, 1, 3, 0, 0, 1, 1, 5, 1, 32'h400, 32'hEB411253, 0);
      pop();

      send(16'h1888, 32'h500, 1'b0);
      check_head("p8", 8, 0, 1, 2, 0, 0, 0, 0, 0, 0, 32'h500, 32'h18880000, 0);
      pop();
      send(16'h4491, 32'h502, 1'b1);
      check_head("p9", 9, 9, 2, 9, 0, 0, 0, 0, 0, 0, 32'h502, 32'h44910000, 1);
      pop();
      send(16'hA20A, 32'h504, 1'b0);
      check_head("p6b", 6, 2, 2, 0, 32'hA, 1, 0, 0, 0, 0, 32'h504, 32'hA20A0000, 0);
      pop();

      // Backpressure: two entries fill the FIFO, the third waits until a pop frees space.
      send(16'h4153, 32'h600, 1'b0);
      send(16'h1C8A, 32'h602, 1'b0);
      chk("full.count", 32'(dec_count), 32'd2);
      chk("full.ready", 32'(fetch_ready), 32'd0);
      fetch_hw = 16'hB003; fetch_pc = 32'h604; fetch_valid = 1'b1;
      tick();
      chk("stall.count", 32'(dec_count), 32'd2);
      check_head("p4", 4, 3, 3, 2, 0, 0, 0, 0, 0, 0, 32'h600, 32'h41530000, 0);
      dec_ready = 1'b1;
      tick();
      chk("pop1.count", 32'(dec_count), 32'd1);
      check_head("p5", 5, 2, 1, 0, 2, 1, 0, 0, 0, 0, 32'h602, 32'h1C8A0000, 0);
      tick();
      fetch_valid = 1'b0; dec_ready = 1'b0;
      chk("pushpop.count", 32'(dec_count), 32'd1);
      check_head("p7", 7, 13, 13, 0, 32'hC, 1, 0, 0, 0, 0, 32'h604, 32'hB0030000, 0);
      pop();
      chk("drain.count", 32'(dec_count), 32'd0);
      pop();
      chk("empty_pop.count", 32'(dec_count), 32'd0);
      chk("empty_pop.ready", 32'(fetch_ready), 32'd1);

      // Flush with a queued entry, a held first halfword and a simultaneous push.
      send(16'h4491, 32'h700, 1'b0);
      send(16'hF141, 32'h702, 1'b0);
      flush = 1'b1; fetch_hw = 16'h1888; fetch_pc = 32'h706; fetch_valid = 1'b1;
      tick();
      flush = 1'b0; fetch_valid = 1'b0;
      chk("flush.count", 32'(dec_count), 32'd0);
      chk("flush.valid", 32'(dec_valid), 32'd0);
      send(16'h3105, 32'h704, 1'b0);
      chk("postflush.count", 32'(dec_count), 32'd1);
      check_head("postflush", 6, 1, 1, 0, 5, 1, 0, 0, 0, 0, 32'h704, 32'h31050000, 0);
      pop();

      send(16'hBF00, 32'h800, 1'b0);
      check_head("undef", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h800, 32'hBF000000, 0);
      pop();
      chk("final.count", 32'(dec_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
